// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage with a one-entry skid buffer in front of IF_ID.
// Redirects flush the slot and skid, and inject a NOP because IF_ID has no valid bit.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        EN,
   input  logic        redirect,
   input  logic [31:0] redirect_PC,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   output logic [31:0] PC_IF,
   output logic [31:0] inst_IF,
   output logic        valid_IF
);
   typedef enum logic {FETCH, WAIT_SLOT} state_t;
   state_t state, state_nx;
   logic [31:0] fetch_pc, fetch_pc_nx, pc_nx, inst_nx, skid_pc, skid_pc_nx, skid_inst, skid_inst_nx;
   logic valid_nx, skid_v, skid_v_nx, slot_free;

   assign slot_free = !valid_IF || EN;
   assign imem_req  = rst && state == FETCH;
   assign imem_addr = fetch_pc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= FETCH;
         fetch_pc  <= RESET_PC;
         PC_IF     <= 32'h0;
         inst_IF   <= NOP_INST;
         valid_IF  <= 1'b0;
         skid_pc   <= 32'h0;
         skid_inst <= NOP_INST;
         skid_v    <= 1'b0;
      end else begin
         state     <= state_nx;
         fetch_pc  <= fetch_pc_nx;
         PC_IF     <= pc_nx;
         inst_IF   <= inst_nx;
         valid_IF  <= valid_nx;
         skid_pc   <= skid_pc_nx;
         skid_inst <= skid_inst_nx;
         skid_v    <= skid_v_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      fetch_pc_nx  = fetch_pc;
      pc_nx        = PC_IF;
      inst_nx      = inst_IF;
      valid_nx     = valid_IF;
      skid_pc_nx   = skid_pc;
      skid_inst_nx = skid_inst;
      skid_v_nx    = skid_v;
      // redirect wins over everything, including an ack arriving this cycle
      if (redirect) begin
         fetch_pc_nx = redirect_PC;
         valid_nx    = 1'b0;
         inst_nx     = NOP_INST;
         skid_v_nx   = 1'b0;
         state_nx    = FETCH;
      end else if (state == FETCH) begin
         if (imem_ack) begin
            fetch_pc_nx = fetch_pc + 32'd4;
            if (slot_free) begin
               pc_nx    = fetch_pc;
               inst_nx  = imem_data;
               valid_nx = 1'b1;
            end else begin
               skid_pc_nx   = fetch_pc;
               skid_inst_nx = imem_data;
               skid_v_nx    = 1'b1;
               state_nx     = WAIT_SLOT;
            end
         end else if (EN) begin
            valid_nx = 1'b0;
            inst_nx  = NOP_INST;
         end
      end else if (EN) begin
         pc_nx     = skid_pc;
         inst_nx   = skid_inst;
         valid_nx  = skid_v;
         skid_v_nx = 1'b0;
         state_nx  = FETCH;
      end
   end
endmodule
